prog_seq: RTL and testbench

Parametrised instruction-fetch sequencer; successor to the single-program PC. Holds the program counter for a configurable number of back-to-back test programs and selects each program's base address on the testbench Start handshake. Supports absolute and signed-relative conditional branches, call/return through a bounded return stack, and a halt/done protocol. Sits between the instruction decoder/ALU flag and the instruction ROM address port.

---
 rtl/seq_pkg.sv | 15 +
 rtl/ret_stack.sv | 49 ++++
 rtl/prog_seq.sv | 146 ++++++++++++++
 tb/tb_prog_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-program instruction-fetch sequencer.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} seq_state_t;

  localparam int MAX_PROG = 8;

  // Entries beyond NPROG are never selected; they only keep the table full-sized.
  localparam int unsigned BASE_ADDR [MAX_PROG] = '{0, 200, 500, 600, 700, 800, 900, 1000};

  function automatic int unsigned base_addr(input logic [2:0] n);
    return BASE_ADDR[n];
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Register-based return-address stack with combinational top-of-stack read.
module ret_stack #(
  parameter int A     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [A-1:0] din,
  output logic [A-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [A-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign wr_idx  = ptr[IW-1:0];
  assign top_idx = ptr[IW-1:0] - IW'(1);
  assign empty   = (ptr == '0);
  assign full    = ptr[PW-1];
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push && !full && wr_idx == IW'(gi)) begin
        mem[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/prog_seq.sv
// Program counter for a series of test programs: Start handshake picks each
// program's base, then branches, call/return and halt steer the fetch address.
module prog_seq
  import seq_pkg::*;
#(
  parameter int A     = 10,
  parameter int NPROG = 3,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Halt,
  input  logic         BranchAbsEn,
  input  logic         BranchRelEn,
  input  logic         CallEn,
  input  logic         RetEn,
  input  logic         ALU_flag,
  input  logic [A-1:0] Target,
  output logic [A-1:0] ProgCtr,
  output logic [2:0]   ProgIdx,
  output logic         Running,
  output logic         Done,
  output logic         AllDone,
  output logic         StackErr
);

  seq_state_t   state, state_next;
  logic [A-1:0] pc_next, pc_inc, stack_top;
  logic [2:0]   idx_next;
  logic [3:0]   prog_cnt, prog_cnt_next;
  logic         running_next, done_next, all_done_next, stack_err_next;
  logic         start_r, rise_q, fall_q;
  logic         push, pop, clear, stack_empty, stack_full;

  assign pc_inc = ProgCtr + A'(1);

  ret_stack #(.A(A), .DEPTH(DEPTH)) u_stack (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      ProgIdx  <= '0;
      Running  <= 1'b0;
      Done     <= 1'b0;
      AllDone  <= 1'b0;
      StackErr <= 1'b0;
      prog_cnt <= '0;
      start_r  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state    <= state_next;
      ProgCtr  <= pc_next;
      ProgIdx  <= idx_next;
      Running  <= running_next;
      Done     <= done_next;
      AllDone  <= all_done_next;
      StackErr <= stack_err_next;
      prog_cnt <= prog_cnt_next;
      start_r  <= Start;
      // Edges are registered so every output stays a pure register.
      rise_q   <= !start_r && Start;
      fall_q   <= start_r && !Start;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = ProgCtr;
    idx_next       = ProgIdx;
    running_next   = Running;
    done_next      = 1'b0;
    all_done_next  = AllDone;
    stack_err_next = StackErr;
    prog_cnt_next  = prog_cnt;
    push           = 1'b0;
    pop            = 1'b0;
    clear          = 1'b0;

    case (state)
      IDLE: begin
        // Once every program has run, further Start requests are ignored.
        if (rise_q && int'(prog_cnt) < NPROG) state_next = ARMED;
      end
      ARMED: begin
        if (fall_q) begin
          if (int'(prog_cnt) < NPROG) begin
            pc_next       = A'(base_addr(prog_cnt[2:0]));
            idx_next      = prog_cnt[2:0];
            prog_cnt_next = prog_cnt + 4'd1;
            clear         = 1'b1;
            running_next  = 1'b1;
            state_next    = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      RUN: begin
        if (Halt) begin
          running_next = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
          if (int'(ProgIdx) == NPROG - 1) all_done_next = 1'b1;
        end else if (RetEn) begin
          if (!stack_empty) begin
            pc_next = stack_top;
            pop     = 1'b1;
          end else begin
            pc_next        = pc_inc;
            stack_err_next = 1'b1;
          end
        end else if (CallEn) begin
          if (!stack_full) begin
            pc_next = Target;
            push    = 1'b1;
          end else begin
            pc_next        = pc_inc;
            stack_err_next = 1'b1;
          end
        end else if (BranchAbsEn && ALU_flag) begin
          pc_next = Target;
        end else if (BranchRelEn && ALU_flag) begin
          // Same-width two's-complement add is the sign-extended offset mod 2^A.
          pc_next = ProgCtr + Target;
        end else begin
          pc_next = pc_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: handshake, branches, call/return, halt and reset.
module tb_prog_seq;

  localparam int A = 10;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         Halt = 1'b0;
  logic         BranchAbsEn = 1'b0;
  logic         BranchRelEn = 1'b0;
  logic         CallEn = 1'b0;
  logic         RetEn = 1'b0;
  logic         ALU_flag = 1'b0;
  logic [A-1:0] Target = '0;
  logic [A-1:0] ProgCtr;
  logic [2:0]   ProgIdx;
  logic         Running, Done, AllDone, StackErr;

  int n_pass  = 0;
  int n_total = 0;

  prog_seq #(.A(A), .NPROG(3), .DEPTH(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Halt        (Halt),
    .BranchAbsEn (BranchAbsEn),
    .BranchRelEn (BranchRelEn),
    .CallEn      (CallEn),
    .RetEn       (RetEn),
    .ALU_flag    (ALU_flag),
    .Target      (Target),
    .ProgCtr     (ProgCtr),
    .ProgIdx     (ProgIdx),
    .Running     (Running),
    .Done        (Done),
    .AllDone     (AllDone),
    .StackErr    (StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One RUN cycle with the given controls, then all controls back to idle.
  task automatic cyc(input logic h, input logic ab, input logic re, input logic ca,
                     input logic rt, input logic fl, input logic [A-1:0] tg);
    Halt = h; BranchAbsEn = ab; BranchRelEn = re; CallEn = ca; RetEn = rt;
    ALU_flag = fl; Target = tg;
    step(1);
    Halt = 0; BranchAbsEn = 0; BranchRelEn = 0; CallEn = 0; RetEn = 0;
    ALU_flag = 0; Target = '0;
  endtask

  // Three-cycle Start pulse; returns just after the edge that samples the fall.
  task automatic start_pulse();
    Start = 1'b1;
    step(3);
    Start = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_pc", ProgCtr, 0);
    chk("rst_idx", ProgIdx, 0);
    chk("rst_running", Running, 0);
    chk("rst_done", Done, 0);
    chk("rst_alldone", AllDone, 0);
    chk("rst_stackerr", StackErr, 0);
    Reset_n = 1'b1;
    step(1);

    start_pulse();
    step(1);
    chk("p0_pc0", ProgCtr, 0);
    chk("p0_running", Running, 1);
    chk("p0_idx", ProgIdx, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk($sformatf("p0_pc%0d", i), ProgCtr, i);
    end

    cyc(0, 1, 0, 0, 0, 1, 10'd20);
    chk("abs_jump", ProgCtr, 20);
    cyc(0, 0, 1, 0, 0, 1, 10'h3FD);
    chk("rel_minus3", ProgCtr, 17);
    cyc(0, 1, 0, 0, 0, 1, 10'd20);
    cyc(0, 0, 1, 0, 0, 0, 10'h3FD);
    chk("rel_flag_low", ProgCtr, 21);
    cyc(0, 1, 0, 0, 0, 0, 10'd5);
    chk("abs_flag_low", ProgCtr, 22);
    cyc(0, 1, 0, 0, 0, 1, 10'd5);

    cyc(0, 0, 0, 1, 0, 0, 10'd100);
    chk("call", ProgCtr, 100);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("ret", ProgCtr, 6);
    cyc(0, 0, 0, 1, 0, 0, 10'd100);
    cyc(0, 0, 0, 1, 0, 0, 10'd200);
    cyc(0, 0, 0, 1, 0, 0, 10'd300);
    cyc(0, 0, 0, 1, 0, 0, 10'd400);
    chk("call4_pc", ProgCtr, 400);
    chk("call4_err", StackErr, 0);
    cyc(0, 0, 0, 1, 0, 0, 10'd500);
    chk("call5_pc", ProgCtr, 401);
    chk("call5_err", StackErr, 1);
    cyc(0, 0, 0, 1, 1, 0, 10'd600);
    chk("ret_over_call", ProgCtr, 301);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("ret2", ProgCtr, 201);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("ret3", ProgCtr, 101);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("ret4", ProgCtr, 7);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("ret_empty", ProgCtr, 8);

    cyc(0, 1, 0, 0, 0, 1, 10'h3FF);
    step(1);
    chk("wrap_inc", ProgCtr, 0);
    cyc(0, 0, 1, 0, 0, 1, 10'h3FF);
    chk("wrap_rel", ProgCtr, 1023);

    cyc(0, 1, 0, 0, 0, 1, 10'd40);
    cyc(1, 0, 0, 0, 0, 0, 10'd0);
    chk("halt_pc", ProgCtr, 40);
    chk("halt_done", Done, 1);
    chk("halt_running", Running, 0);
    chk("halt_alldone", AllDone, 0);
    step(1);
    chk("done_once", Done, 0);
    step(3);
    chk("idle_hold", ProgCtr, 40);

    start_pulse();
    chk("p1_fall_edge_pc", ProgCtr, 40);
    step(1);
    chk("p1_pc", ProgCtr, 200);
    chk("p1_idx", ProgIdx, 1);
    chk("p1_running", Running, 1);
    step(2);
    chk("p1_pc_inc", ProgCtr, 202);
    cyc(1, 0, 0, 0, 0, 0, 10'd0);
    chk("p1_done", Done, 1);
    chk("p1_alldone", AllDone, 0);
    step(1);

    start_pulse();
    step(1);
    chk("p2_pc", ProgCtr, 500);
    chk("p2_idx", ProgIdx, 2);
    cyc(1, 0, 0, 0, 0, 0, 10'd0);
    chk("p2_done", Done, 1);
    chk("p2_alldone", AllDone, 1);
    step(1);

    start_pulse();
    step(3);
    chk("p3_ignored_pc", ProgCtr, 500);
    chk("p3_ignored_running", Running, 0);
    chk("p3_ignored_idx", ProgIdx, 2);

    Reset_n = 1'b0;
    step(1);
    Reset_n = 1'b1;
    step(1);
    start_pulse();
    step(1);
    cyc(0, 1, 0, 0, 0, 1, 10'd100);
    cyc(0, 0, 0, 1, 0, 0, 10'd103);
    chk("chain_pc", ProgCtr, 103);
    Reset_n = 1'b0;
    CallEn = 1'b1;
    Target = 10'd300;
    step(1);
    CallEn = 1'b0;
    Target = '0;
    chk("mid_rst_pc", ProgCtr, 0);
    chk("mid_rst_idx", ProgIdx, 0);
    chk("mid_rst_running", Running, 0);
    chk("mid_rst_alldone", AllDone, 0);
    chk("mid_rst_stackerr", StackErr, 0);
    Reset_n = 1'b1;
    step(1);
    start_pulse();
    step(1);
    chk("restart_pc", ProgCtr, 0);
    cyc(0, 0, 0, 0, 1, 0, 10'd0);
    chk("restart_ret_pc", ProgCtr, 1);
    chk("restart_ret_err", StackErr, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
